frame_timer_arbiter: RTL
========================

# frame_timer_arbiter

Shares one frame-rate timing resource between four game-logic requesters, such as hook swing, hook reel, score flash and level countdown. The resource is a cycle divider that produces frame ticks plus a frame down-counter. Each requester asks for a delay of N frames. A round-robin FSM grants the timer to one requester at a time, runs the countdown and returns a one-cycle done pulse to the winner. The block sits between the game controller FSMs and the 50 MHz system clock domain.

## Interface
Parameters:
- TICK_DIV, 833334 — clk cycles per frame tick (60 Hz at 50 MHz); legal range 2..2^20-1.
- FW, 6 — width of each frame-count request.

Ports:
- clk  in  1  — system clock; all logic on posedge.
- reset  in  1  — synchronous, active-high.
- req  in  4  — level request per requester; held until done or abort.
- req_frames  in  4*FW  — frame count for requester i at bits [i*FW +: FW]; sampled only in GRANT.
- grant  out  4  — one-hot owner of the timer; 0 when idle.
- done  out  4  — one-hot, one-cycle pulse to the owner at countdown end.
- busy  out  1  — high in GRANT, RUN and DONE.
- frame_tick  out  1  — one-cycle pulse per elapsed frame while in RUN.
- pause  in  1  — present only with FRAME_TIMER_PAUSE_EN.

## Operation
- FSM states: IDLE, GRANT, RUN, DONE.
- **IDLE**
  - grant=0.
  - If any req is high, select the first set bit scanning from rr_ptr upward modulo 4.
  - Register that one-hot value in grant and go to GRANT.
- **GRANT** (1 cycle)
  - Load frame_cnt (FW bits) from the owner's req_frames slice; clear delay_cnt (20 bits).
  - Set rr_ptr = owner+1 mod 4.
  - If the loaded value is 0, go to DONE; otherwise go to RUN.
- **RUN**
  - delay_cnt increments every cycle.
  - When delay_cnt == TICK_DIV-1: clear delay_cnt, pulse frame_tick, decrement frame_cnt.
  - If frame_cnt was 1 at that tick, go to DONE.
- **DONE** (1 cycle)
  - done = grant; grant is held.
  - Next state is IDLE with grant cleared.
- **Abort**
  - If the owner's req falls in GRANT or RUN, go to IDLE next cycle.
  - No done pulse and no frame_tick for the abort cycle.
  - rr_ptr is already advanced.
- **Reissue after done**
  - A requester whose req stays high after done is eligible again.
  - Round-robin order still favours the other requesters first.
- **Simultaneous events**
  - If the abort condition and the final tick occur in the same cycle, abort wins: no done.
  - Changes to req_frames outside GRANT are ignored.
- **Counter behaviour**
  - delay_cnt and frame_cnt never wrap.
  - Both counters are cleared on entry to IDLE.
- **Reset**
  - Values: state=IDLE, rr_ptr=0, grant=0, done=0, busy=0, frame_tick=0, counters=0.
  - Reset mid-run discards the transaction with no done.

## Timing
- All outputs are registered.
- req high at edge n in IDLE → grant and busy high from edge n+1 (entry to GRANT).
- For F≥1:
  - RUN lasts exactly F*TICK_DIV cycles.
  - The k-th frame_tick occurs 1 + k*TICK_DIV cycles after grant rises.
  - done is high for one cycle, starting F*TICK_DIV+1 cycles after grant rises.
- For F=0: done is high in the cycle 1 after grant rises.
- grant and busy fall one cycle after done.
- Minimum IDLE dwell between transactions is 1 cycle.
- Back-to-back service period for one requester is F*TICK_DIV+3 cycles.

## Configuration
- FRAME_TIMER_PAUSE_EN defined:
  - Adds the pause input.
  - In RUN with pause=1, delay_cnt and frame_cnt hold and frame_tick stays 0.
  - Abort and reset still apply.
  - pause has no effect in other states.
- FRAME_TIMER_PAUSE_EN undefined:
  - No pause port.
  - RUN always counts.

## Test plan
Use TICK_DIV=4, FW=6.
- **Reset values:** reset high 3 cycles with req=4'b1111 → grant, done, busy and frame_tick all 0 throughout; first grant 4'b0001 at 1 cycle after reset falls.
- **Single request:** req[2]=1, frames=3 → grant=4'b0100 next edge; frame_tick at +5, +9, +13 cycles from grant rise; done=4'b0100 at +13 for one cycle; grant clears at +14.
- **Round-robin:** req=4'b1111 held, all frames=1 → grants in order 0001, 0010, 0100, 1000, 0001; each done 5 cycles after its grant rises.
- **Zero frames:** req[1]=1, frames=0 → done=4'b0010 one cycle after grant rises; no frame_tick.
- **Abort and reset:**
  - Owner 0 with frames=5 drops req at cycle 7 of RUN → grant=0 next cycle, no done; pending req[3] is granted next.
  - Separately, reset asserted mid-RUN → all outputs 0 next cycle.
- **Pause** (FRAME_TIMER_PAUSE_EN): frames=2 with pause=1 for 10 RUN cycles → done delayed by exactly 10 cycles, to +19; without the macro, done at +9.

Source files
------------

// File: rtl/frame_timer_arbiter.sv
// frame_timer_arbiter
//
// Shares one frame-rate timer between four requesters. A round-robin FSM
// grants the timer to one requester, counts N frames (each frame is TICK_DIV
// clk cycles) and returns a one-cycle done pulse to that requester.
//
// Parameters:
//   TICK_DIV    clk cycles per frame tick (2 .. 2^20-1)
//   FW          width of each frame-count request
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high
//   req[3:0]    level request per requester, held until done or abort
//   req_frames  frame count for requester i at [i*FW +: FW], sampled in GRANT
//   pause       (only with FRAME_TIMER_PAUSE_EN) freezes counting in RUN
//   grant[3:0]  one-hot owner of the timer, 0 when idle
//   done[3:0]   one-hot, one-cycle pulse to the owner at countdown end
//   busy        high in GRANT, RUN and DONE
//   frame_tick  one-cycle pulse per elapsed frame while in RUN
//
// Build option:
//   FRAME_TIMER_PAUSE_EN  adds the pause input; otherwise RUN always counts.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; pick next requester round-robin from rr_ptr
// GRANT | load frame count from owner's slice, advance rr_ptr
// RUN   | divide clk into frame ticks and count frames down
// DONE  | one-cycle done pulse to owner, then release

module frame_timer_arbiter #(
    parameter int TICK_DIV = 833334,
    parameter int FW       = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      req,
    input  logic [4*FW-1:0] req_frames,
`ifdef FRAME_TIMER_PAUSE_EN
    input  logic            pause,
`endif
    output logic [3:0]      grant,
    output logic [3:0]      done,
    output logic            busy,
    output logic            frame_tick
);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RUN, S_DONE} state_t;

    localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);

    state_t        state, state_nxt;
    logic [1:0]    rr_ptr, rr_ptr_nxt;
    logic [1:0]    owner, owner_nxt;
    logic [1:0]    pick;
    logic [3:0]    grant_nxt, done_nxt;
    logic          tick_nxt;
    logic [19:0]   delay_cnt, delay_nxt;
    logic [FW-1:0] frame_cnt, frame_nxt;
    logic          run_en;
    logic          owner_req;

`ifdef FRAME_TIMER_PAUSE_EN
    assign run_en = ~pause;
`else
    assign run_en = 1'b1;
`endif

    assign owner_req = req[owner];

    // Scan downward in offset so the smallest offset from rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        pick = rr_ptr;
        idx  = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        grant_nxt  = grant;
        done_nxt   = '0;
        tick_nxt   = 1'b0;
        delay_nxt  = delay_cnt;
        frame_nxt  = frame_cnt;

        case (state)
            S_IDLE: begin
                grant_nxt = '0;
                delay_nxt = '0;
                frame_nxt = '0;
                if (|req) begin
                    owner_nxt = pick;
                    grant_nxt = 4'b0001 << pick;
                    state_nxt = S_GRANT;
                end
            end

            S_GRANT: begin
                rr_ptr_nxt = owner + 2'd1;
                delay_nxt  = '0;
                if (!owner_req) begin
                    state_nxt = S_IDLE;
                    grant_nxt = '0;
                    frame_nxt = '0;
                end else begin
                    frame_nxt = req_frames[owner*FW +: FW];
                    if (frame_nxt == '0) begin
                        state_nxt = S_DONE;
                        done_nxt  = grant;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end

            S_RUN: begin
                // Abort takes priority over a coincident final tick.
                if (!owner_req) begin
                    state_nxt = S_IDLE;
                    grant_nxt = '0;
                    delay_nxt = '0;
                    frame_nxt = '0;
                end else if (run_en) begin
                    if (delay_cnt == TICK_LAST) begin
                        delay_nxt = '0;
                        tick_nxt  = 1'b1;
                        if (frame_cnt != '0) begin
                            frame_nxt = frame_cnt - FW'(1);
                        end
                        if (frame_cnt == FW'(1)) begin
                            state_nxt = S_DONE;
                            done_nxt  = grant;
                        end
                    end else begin
                        delay_nxt = delay_cnt + 20'd1;
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
                delay_nxt = '0;
                frame_nxt = '0;
            end

            default: begin
                state_nxt = S_IDLE;
                grant_nxt = '0;
                delay_nxt = '0;
                frame_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            grant      <= '0;
            done       <= '0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            delay_cnt  <= '0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_ptr_nxt;
            owner      <= owner_nxt;
            grant      <= grant_nxt;
            done       <= done_nxt;
            busy       <= (state_nxt != S_IDLE);
            frame_tick <= tick_nxt;
            delay_cnt  <= delay_nxt;
            frame_cnt  <= frame_nxt;
        end
    end

endmodule
